logic_gate_array: RTL and testbench

- Parametrised, clocked successor to the fixed two-input behavioural gates (AND/NAND/OR/NOR/XOR/XNOR/Inv).
- CH independent channels, each an N-input gate with a runtime-selectable function.
- Each channel has a cycle-accurate propagation delay and a glitch filter, modelling delay and rise/fall settling in synthesizable RTL.
- Sits between stimulus/DUT logic and the analog-digital boundary in mixed-mode testbenches and digital models.

---
 rtl/logic_gate_pkg.sv | 49 ++++
 rtl/logic_gate_array_glitch_filter.sv | 64 ++++++
 rtl/logic_gate_array.sv | 56 +++++
 tb/tb_logic_gate_array.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared types and the N-input gate evaluation used by logic_gate_array.
package logic_gate_pkg;

  localparam int unsigned GF_W    = 3;
  localparam int unsigned MAX_N   = 8;

  typedef enum logic [GF_W-1:0] {
    GF_AND  = 3'd0,
    GF_NAND = 3'd1,
    GF_OR   = 3'd2,
    GF_NOR  = 3'd3,
    GF_XOR  = 3'd4,
    GF_XNOR = 3'd5,
    GF_INV  = 3'd6,
    GF_BUF  = 3'd7
  } gate_func_t;

  // Only the low n bits of vec take part; INV/BUF look at input 0 alone.
  function automatic logic gate_eval(input gate_func_t func,
                                     input logic [MAX_N-1:0] vec,
                                     input int unsigned n);
    logic v_and;
    logic v_or;
    logic v_xor;
    logic v_res;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        v_and = v_and & vec[i];
        v_or  = v_or  | vec[i];
        v_xor = v_xor ^ vec[i];
      end
    end
    case (func)
      GF_AND:  v_res = v_and;
      GF_NAND: v_res = ~v_and;
      GF_OR:   v_res = v_or;
      GF_NOR:  v_res = ~v_or;
      GF_XOR:  v_res = v_xor;
      GF_XNOR: v_res = ~v_xor;
      GF_INV:  v_res = ~vec[0];
      default: v_res = vec[0];
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/logic_gate_array_glitch_filter.sv
// Single-bit settling filter: a new level must persist for the threshold before
// it reaches o_q. Macro LOGIC_GATE_ASYM_FILT_EN selects per-direction thresholds.
module glitch_filter #(
`ifdef LOGIC_GATE_ASYM_FILT_EN
  parameter int unsigned RISE_CYC = 2,
  parameter int unsigned FALL_CYC = 2
`else
  parameter int unsigned FILT_CYC = 2
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_pending
);

`ifdef LOGIC_GATE_ASYM_FILT_EN
  localparam int unsigned CNT_MAX = (RISE_CYC > FALL_CYC) ? RISE_CYC : FALL_CYC;
`else
  localparam int unsigned CNT_MAX = FILT_CYC;
`endif
  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic             r_q;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_thr;

  // The pending direction is always the opposite of the current output level.
`ifdef LOGIC_GATE_ASYM_FILT_EN
  assign w_thr = r_q ? CNT_W'(FALL_CYC) : CNT_W'(RISE_CYC);
`else
  assign w_thr = CNT_W'(FILT_CYC);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else if (i_d == r_q) begin
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else if (w_thr == '0) begin
      r_q       <= i_d;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else if (!r_pending) begin
      r_pending <= 1'b1;
      r_cnt     <= CNT_W'(1);
    end else if (r_cnt == w_thr) begin
      r_q       <= ~r_q;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  assign o_q       = r_q;
  assign o_pending = r_pending;

endmodule

// File: rtl/logic_gate_array.sv
// CH-channel N-input gate array with DELAY-cycle pipeline and per-channel glitch
// filter. Define LOGIC_GATE_ASYM_FILT_EN for separate rise/fall thresholds.
module logic_gate_array
  import logic_gate_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned N        = 2,
  parameter int unsigned DELAY    = 1,
`ifdef LOGIC_GATE_ASYM_FILT_EN
  parameter int unsigned RISE_CYC = 2,
  parameter int unsigned FALL_CYC = 2
`else
  parameter int unsigned FILT_CYC = 2
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [GF_W-1:0] func,
  input  logic [CH*N-1:0] in_bus,
  output logic [CH-1:0]   out,
  output logic [CH-1:0]   pending
);

  logic [CH-1:0] w_g;
  logic [CH-1:0] r_pipe [DELAY];

  // Samples carry the function in force when they were taken; no flush on change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DELAY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_g;
      for (int unsigned i = 1; i < DELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign w_g[c] = gate_eval(gate_func_t'(func), MAX_N'(in_bus[c*N +: N]), N);

    glitch_filter #(
`ifdef LOGIC_GATE_ASYM_FILT_EN
      .RISE_CYC (RISE_CYC),
      .FALL_CYC (FALL_CYC)
`else
      .FILT_CYC (FILT_CYC)
`endif
    ) u_filt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_d       (r_pipe[DELAY-1][c]),
      .o_q       (out[c]),
      .o_pending (pending[c])
    );
  end

endmodule

// File: tb/tb_logic_gate_array.sv
// Directed bench: several parameterisations of logic_gate_array share clk/rst_n/func.
module tb_logic_gate_array;

  logic       clk;
  logic       rst_n;
  logic [2:0] func;
  logic [2:0] in_a;
  logic [3:0] in_b;
  logic [0:0] in_c;
  logic [1:0] in_d;
  logic [1:0] in_e;
  logic [0:0] out_a, pend_a, out_c, pend_c, out_d, pend_d, out_e, pend_e;
  logic [1:0] out_b, pend_b;

  int total = 0;
  int bad   = 0;

  logic_gate_array #(.CH(1), .N(3), .DELAY(1), .FILT_CYC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .func(func), .in_bus(in_a), .out(out_a), .pending(pend_a));
  logic_gate_array #(.CH(2), .N(2), .DELAY(3), .FILT_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .func(func), .in_bus(in_b), .out(out_b), .pending(pend_b));
  logic_gate_array #(.CH(1), .N(1), .DELAY(1), .FILT_CYC(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .func(func), .in_bus(in_c), .out(out_c), .pending(pend_c));
  logic_gate_array #(.CH(1), .N(2), .DELAY(2), .FILT_CYC(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .func(func), .in_bus(in_d), .out(out_d), .pending(pend_d));
  logic_gate_array #(.CH(1), .N(2), .DELAY(4), .FILT_CYC(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .func(func), .in_bus(in_e), .out(out_e), .pending(pend_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] f;
    logic [2:0] v;
    logic       e;
  } tt_vec_t;

  tt_vec_t tv [16];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic ref_gate(input logic [2:0] f, input logic [2:0] v);
    int ones;
    ones = $countones(v);
    case (f)
      3'd0:    ref_gate = (ones == 3);
      3'd1:    ref_gate = (ones != 3);
      3'd2:    ref_gate = (ones != 0);
      3'd3:    ref_gate = (ones == 0);
      3'd4:    ref_gate = (ones % 2 == 1);
      3'd5:    ref_gate = (ones % 2 == 0);
      3'd6:    ref_gate = ~v[0];
      default: ref_gate = v[0];
    endcase
  endfunction

  initial begin
    tv[0]  = '{3'd0, 3'b111, 1'b1};  tv[1]  = '{3'd0, 3'b110, 1'b0};
    tv[2]  = '{3'd1, 3'b111, 1'b0};  tv[3]  = '{3'd1, 3'b011, 1'b1};
    tv[4]  = '{3'd2, 3'b000, 1'b0};  tv[5]  = '{3'd2, 3'b100, 1'b1};
    tv[6]  = '{3'd3, 3'b000, 1'b1};  tv[7]  = '{3'd3, 3'b010, 1'b0};
    tv[8]  = '{3'd4, 3'b111, 1'b1};  tv[9]  = '{3'd4, 3'b011, 1'b0};
    tv[10] = '{3'd5, 3'b101, 1'b1};  tv[11] = '{3'd5, 3'b100, 1'b0};
    tv[12] = '{3'd6, 3'b110, 1'b1};  tv[13] = '{3'd6, 3'b001, 1'b0};
    tv[14] = '{3'd7, 3'b001, 1'b1};  tv[15] = '{3'd7, 3'b110, 1'b0};

    rst_n = 1'b0; func = 3'd0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
    tick(2);
    check("reset out", 8'({out_a, out_b, out_c, out_d, out_e}), 8'h00);
    check("reset pending", 8'({pend_a, pend_b, pend_c, pend_d, pend_e}), 8'h00);

    // Reset must dominate an inverting function and active inputs.
    func = 3'd1; in_b = 4'b1111; in_d = 2'b11;
    tick(3);
    check("reset dominance out", 8'({out_a, out_b, out_c, out_d, out_e}), 8'h00);
    check("reset dominance pending", 8'({pend_a, pend_b, pend_c, pend_d, pend_e}), 8'h00);
    func = 3'd0; in_b = '0; in_d = '0;
    tick(1);
    rst_n = 1'b1;
    tick(12);

    // Truth table: hand vectors, then full sweep.
    for (int i = 0; i < 16; i++) begin
      func = tv[i].f; in_a = tv[i].v;
      tick(2);
      check($sformatf("tt hand %0d", i), 8'(out_a), 8'(tv[i].e));
    end
    for (int f = 0; f < 8; f++) begin
      for (int v = 0; v < 8; v++) begin
        func = 3'(f); in_a = 3'(v);
        tick(2);
        check($sformatf("tt sweep f%0d v%0d", f, v), 8'(out_a), 8'(ref_gate(3'(f), 3'(v))));
      end
    end
    check("tt pending", 8'(pend_a), 8'h00);

    // Latency with DELAY=3, FILT_CYC=2: sample at e, pending e+3..e+4, out at e+5.
    func = 3'd0; in_b = 4'b0000;
    tick(10);
    in_b = 4'b1111;
    tick(1);
    tick(2);
    check("lat e+2 out", 8'(out_b), 8'h0);
    check("lat e+2 pending", 8'(pend_b), 8'h0);
    tick(1);
    check("lat e+3 out", 8'(out_b), 8'h0);
    check("lat e+3 pending", 8'(pend_b), 8'h3);
    tick(1);
    check("lat e+4 pending", 8'(pend_b), 8'h3);
    tick(1);
    check("lat e+5 out", 8'(out_b), 8'h3);
    check("lat e+5 pending", 8'(pend_b), 8'h0);
    in_b = 4'b0011;
    tick(4);
    check("indep e+3 out", 8'(out_b), 8'h3);
    check("indep e+3 pending", 8'(pend_b), 8'h2);
    tick(2);
    check("indep e+5 out", 8'(out_b), 8'h1);
    check("indep e+5 pending", 8'(pend_b), 8'h0);

    // Glitch rejection with FILT_CYC=3: 3-sample pulse dropped, 4-sample pulse passes.
    func = 3'd7; in_c = 1'b0;
    tick(10);
    for (int len = 3; len <= 4; len++) begin
      in_c = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick(1);
        if (k == len - 1) in_c = 1'b0;
        check($sformatf("glitch len%0d k%0d out", len, k), 8'(out_c),
              8'((len == 4) && (k >= 4) && (k <= 7)));
        check($sformatf("glitch len%0d k%0d pending", len, k), 8'(pend_c),
              8'(((k >= 1) && (k <= 3)) || ((len == 4) && (k >= 5) && (k <= 7))));
      end
      tick(5);
    end

    // Reset mid-count with FILT_CYC=4, then NAND start-up transient.
    func = 3'd7; in_d = 2'b00;
    tick(10);
    in_d = 2'b01;
    tick(3);
    check("midrst counting pending", 8'(pend_d), 8'h1);
    check("midrst counting out", 8'(out_d), 8'h0);
    rst_n = 1'b0;
    tick(1);
    check("midrst reset out", 8'(out_d), 8'h0);
    check("midrst reset pending", 8'(pend_d), 8'h0);
    func = 3'd1; in_d = 2'b00; rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("startup r+%0d out", k), 8'(out_d), 8'(k >= 7));
      check($sformatf("startup r+%0d pending", k), 8'(pend_d), 8'((k >= 3) && (k <= 6)));
    end

    // func switch in flight with DELAY=4, FILT_CYC=1: old samples stay AND.
    func = 3'd0; in_e = 2'b11;
    tick(12);
    check("fswitch settled out", 8'(out_e), 8'h1);
    func = 3'd1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check($sformatf("fswitch e+%0d out", k), 8'(out_e), 8'(k < 5));
      check($sformatf("fswitch e+%0d pending", k), 8'(pend_e), 8'(k == 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
